// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CHIP-8 RAM arbiter: requester ids, address/byte types,
// arbiter state encoding and a small id-to-one-hot helper.
// No logic, no latency, no backpressure of its own.
package mem_arbiter_pkg;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    REQ_MEM   = 2'd0,
    REQ_DRAW  = 2'd1,
    REQ_FETCH = 2'd2
  } req_id_e;

  typedef logic [11:0] addr_t;
  typedef logic [7:0]  byte_t;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_e;

  function automatic logic [N_REQ-1:0] id_onehot(req_id_e id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the RAM arbiter: per-requester request/lock/write
// command fields in, grant/stall/read-valid strobes and shared read data out.
// Grant is combinational on the request; read data follows a read grant by 1 cycle.
// Ports: master = requesters (pipeline, draw unit, fetch), slave = arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) ();

  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0]             lock;
  logic [N_REQ-1:0]             we;
  logic [N_REQ-1:0][ADDR_W-1:0] addr;
  logic [N_REQ-1:0][DATA_W-1:0] wdata;
  logic [N_REQ-1:0]             gnt;
  logic [N_REQ-1:0]             stall;
  logic [N_REQ-1:0]             rvalid;
  logic [DATA_W-1:0]            rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, stall, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, stall, rvalid, rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Fixed-priority picker: mem > draw > fetch, fetch first when promoted.
// Purely combinational, zero latency.
// No backpressure; an empty request vector yields an all-zero grant.
// Ports: req (request vector), promote (starved fetch), gnt (one-hot or zero).
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             promote,
  output logic [N_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (promote && req[REQ_FETCH]) begin
      gnt[REQ_FETCH] = 1'b1;
    end else if (req[REQ_MEM]) begin
      gnt[REQ_MEM] = 1'b1;
    end else if (req[REQ_DRAW]) begin
      gnt[REQ_DRAW] = 1'b1;
    end else if (req[REQ_FETCH]) begin
      gnt[REQ_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port CHIP-8 RAM between mem stage, draw unit and fetch.
// Grant and command are same-cycle; read data/rvalid return 1 cycle after a read grant.
// Losing requesters see stall = req & ~gnt; a lock holds the RAM until released or req drops.
// Ports: clk, rst (sync, active-low), bus (requester side, slave modport),
//        mem_addr/mem_we/mem_wdata (RAM command), mem_rdata (registered RAM read data).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e           state_q, state_d;
  req_id_e              owner_q, owner_d;
  logic [STARVE_W-1:0]  starve_q;
  logic [N_REQ-1:0]     rvalid_q;
  logic [ADDR_W-1:0]    addr_hold_q;

  logic                 promote;
  logic                 owner_holds;
  logic [N_REQ-1:0]     pick_gnt;
  logic [N_REQ-1:0]     gnt_c;
  logic                 any_gnt;
  req_id_e              sel;

  assign promote = (starve_q == STARVE_W'(STARVE_LIMIT));

  mem_arb_pick u_pick (
    .req     (bus.req),
    .promote (promote),
    .gnt     (pick_gnt)
  );

  // A lock only holds while its owner keeps requesting; once the owner drops
  // req, free arbitration takes over in the same cycle (no dead cycle).
  assign owner_holds = (state_q == ARB_LOCKED) && bus.req[owner_q];

  always_comb begin
    gnt_c = '0;
    if (!rst) begin
      gnt_c = '0;
    end else if (owner_holds) begin
      gnt_c = id_onehot(owner_q);
    end else begin
      gnt_c = pick_gnt;
    end
  end

  assign any_gnt = |gnt_c;

  always_comb begin
    sel = REQ_MEM;
    if (gnt_c[REQ_DRAW])  sel = REQ_DRAW;
    if (gnt_c[REQ_FETCH]) sel = REQ_FETCH;
  end

  // Command mux. With no grant the address is held from the last access so the
  // RAM address bus does not toggle needlessly; the write strobe stays low.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (any_gnt) begin
      mem_addr  = bus.addr[sel];
      mem_we    = bus.we[sel];
      mem_wdata = bus.wdata[sel];
    end else if (rst) begin
      mem_addr  = addr_hold_q;
    end
  end

  // Ownership follows the lock bit of whoever is granted this cycle; any
  // granted cycle without lock (or no grant at all) returns to FREE.
  always_comb begin
    state_d = ARB_FREE;
    owner_d = owner_q;
    if (|(gnt_c & bus.lock)) begin
      state_d = ARB_LOCKED;
      owner_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_FREE;
      owner_q     <= REQ_MEM;
      starve_q    <= '0;
      rvalid_q    <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rvalid_q <= gnt_c & ~bus.we;
      if (any_gnt) begin
        addr_hold_q <= mem_addr;
      end
      // Saturate at the limit so promotion persists until fetch wins.
      if (bus.req[REQ_FETCH] && !gnt_c[REQ_FETCH]) begin
        if (!promote) begin
          starve_q <= starve_q + STARVE_W'(1);
        end
      end else begin
        starve_q <= '0;
      end
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.stall  = rst ? (bus.req & ~gnt_c) : '0;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, every cycle
// compared against a requester-level reference model and a behavioural RAM.
// Ports: none (top-level bench).
module tb_mem_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_pat(logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]};
  endfunction

  // Behavioural single-port RAM with registered read.
  logic [7:0] ram    [0:4095];
  bit         ram_wr [0:4095];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_pat(mem_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (requester level).
  logic [7:0]  ref_mem [0:4095];
  int          owner    = -1;
  int          starve   = 0;
  logic [2:0]  exp_rv   = 3'b000;
  logic [7:0]  exp_rd   = 8'h00;
  logic [11:0] hold     = 12'h000;

  // Check one cycle: inputs are already driven; sample at negedge, then
  // advance the model to the state after the coming rising edge.
  task automatic step();
    int         g;
    logic [2:0] eg;
    logic [11:0] a;
    @(negedge clk);
    g  = -1;
    eg = 3'b000;
    if (rst) begin
      if (owner >= 0 && bus.req[owner]) g = owner;
      else if (starve == LIMIT && bus.req[2]) g = 2;
      else begin
        for (int i = 0; i < 3; i++) if (bus.req[i] && g < 0) g = i;
      end
    end
    if (g >= 0) eg[g] = 1'b1;

    check("gnt", 32'(bus.gnt), 32'(eg));
    check("stall", 32'(bus.stall), rst ? 32'(bus.req & ~eg) : 32'd0);
    check("mem_we", 32'(mem_we), (g >= 0) ? 32'(bus.we[g]) : 32'd0);
    check("mem_addr", 32'(mem_addr), (g >= 0) ? 32'(bus.addr[g]) : (rst ? 32'(hold) : 32'd0));
    if (g >= 0) check("mem_wdata", 32'(mem_wdata), 32'(bus.wdata[g]));
    else if (!rst) check("mem_wdata_rst", 32'(mem_wdata), 32'd0);
    check("rvalid", 32'(bus.rvalid), 32'(exp_rv));
    if (exp_rv != 3'b000) check("rdata", 32'(bus.rdata), 32'(exp_rd));

    if (!rst) begin
      owner  = -1;
      starve = 0;
      exp_rv = 3'b000;
      hold   = 12'h000;
    end else begin
      exp_rv = 3'b000;
      if (g >= 0) begin
        a    = bus.addr[g];
        hold = a;
        if (bus.we[g]) ref_mem[a] = bus.wdata[g];
        else begin
          exp_rv[g] = 1'b1;
          exp_rd    = ref_mem[a];
        end
        owner = bus.lock[g] ? g : -1;
      end else begin
        owner = -1;
      end
      if (bus.req[2] && g != 2) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
    bus.req  = r;
    bus.lock = l;
    bus.we   = w;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_pat(12'(i));
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < 3; i++) bus.addr[i] = 12'(16 * i + 1);

    // Reset with all requesters active and the mem stage writing.
    rst = 1'b0;
    drive(3'b111, 3'b000, 3'b001);
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b1;
    step();

    // Priority and read latency: draw beats fetch.
    bus.addr[2] = 12'h200;
    bus.addr[1] = 12'h050;
    drive(3'b110, 3'b000, 3'b000);
    step();
    drive(3'b000, 3'b000, 3'b000);
    step();

    // Locked 16-byte mem-stage write burst with fetch requesting throughout.
    for (int k = 0; k < 16; k++) begin
      bus.addr[0]  = 12'h300 + 12'(k);
      bus.wdata[0] = 8'(8'hA0 + k);
      drive(3'b101, (k < 15) ? 3'b001 : 3'b000, 3'b001);
      step();
    end
    drive(3'b100, 3'b000, 3'b000);
    step();
    drive(3'b000, 3'b000, 3'b000);
    step();

    // Draw lock, then draw drops req while the mem stage asks.
    bus.addr[1] = 12'h304;
    bus.addr[0] = 12'h30F;
    drive(3'b010, 3'b010, 3'b000);
    step();
    step();
    drive(3'b001, 3'b000, 3'b000);
    step();
    drive(3'b000, 3'b000, 3'b000);
    step();

    // Starvation: mem and draw alternate, fetch held.
    for (int k = 0; k < 12; k++) begin
      drive((k % 2 == 0) ? 3'b101 : 3'b110, 3'b000, 3'b000);
      step();
    end
    drive(3'b000, 3'b000, 3'b000);
    step();

    // Reset in the middle of a locked mem-stage burst.
    for (int k = 0; k < 5; k++) begin
      bus.addr[0]  = 12'h310 + 12'(k);
      bus.wdata[0] = 8'(8'h50 + k);
      drive(3'b001, 3'b001, 3'b001);
      step();
    end
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    drive(3'b110, 3'b000, 3'b000);
    step();
    drive(3'b000, 3'b000, 3'b000);
    step();

    // Random traffic over a small address window so reads hit written bytes.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < 3; i++) begin
        bus.addr[i]  = 12'h300 + 12'($urandom_range(0, 31));
        bus.wdata[i] = 8'($urandom);
      end
      drive(3'($urandom), 3'($urandom), 3'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 4 KiB CHIP-8 RAM between three requesters: the memory-access stage (Fx55/Fx65/Fx33 loads and stores), the draw unit (Dxyn sprite reads) and instruction fetch.
- Uses fixed priority with a burst lock and a starvation guard for fetch.
- Drives the RAM command port and returns read data with per-requester valid strobes.
- Produces per-requester stall signals that feed the pipeline stall network.

Parameters:
- ADDR_W, 12, RAM address width
- DATA_W, 8, RAM data width
- STARVE_LIMIT, 8, consecutive denied fetch cycles before fetch is promoted to top priority

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- req  in  [2:0]  request per requester; index 0 = mem stage, 1 = draw, 2 = fetch
- lock  in  [2:0]  hold ownership after this granted access
- we  in  [2:0]  write enable per requester (1 = write)
- addr  in  [2:0][ADDR_W-1:0]  address per requester
- wdata  in  [2:0][DATA_W-1:0]  write data per requester
- gnt  out  [2:0]  one-hot grant; the access is issued this cycle
- stall  out  [2:0]  req & ~gnt
- rvalid  out  [2:0]  read data valid for the requester granted a read in the previous cycle
- rdata  out  DATA_W  shared read data, equal to mem_rdata
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write strobe
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, registered, valid 1 cycle after the address is presented

Behaviour:
- Reset (rst low at a clk edge):
  - owner state goes to NONE; the starvation counter clears; rvalid goes to 0.
  - While rst is low, gnt, stall and mem_we are forced to 0, mem_addr to 0 and mem_wdata to 0.
  - A lock in progress is abandoned. No read data is returned for accesses granted in the reset cycle.
- State machine:
  - FREE: no owner.
  - LOCKED(i): requester i owns the RAM.
- Arbitration in FREE (combinational, same cycle):
  - Pick the highest-priority asserted req. The order is 0 > 1 > 2, except when starve_cnt == STARVE_LIMIT, when fetch (2) is first.
  - gnt is one-hot or zero.
- Command port:
  - The granted requester's addr, we and wdata are muxed onto mem_addr, mem_we and mem_wdata in the same cycle.
  - With no grant, mem_we = 0 and mem_addr holds its last value (registered hold, no spurious write).
- Read return: if gnt[i] & ~we[i] at cycle t, then rvalid[i] = 1 at t+1 and rdata = mem_rdata. Writes produce no rvalid. Latency is 1 cycle.
- Lock entry: FREE -> LOCKED(i) when gnt[i] & lock[i] at the edge.
- In LOCKED(i):
  - gnt[i] = req[i]; all other grants are 0, regardless of priority or starvation.
  - Stays LOCKED while req[i] & lock[i].
  - Returns to FREE after a granted cycle with lock[i] = 0.
- Owner drops req while LOCKED(i): the lock is released in that same cycle and FREE arbitration applies combinationally in that cycle. There is no dead cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle with req[2] & ~gnt[2].
  - Clears on gnt[2] or when req[2] = 0.
  - Promotion applies only at FREE arbitration. A lock is never pre-empted.
- A fetch burst of 2 bytes uses lock on the first byte only. The mem stage may lock for up to 16 bytes (Fx55/Fx65, V0..VF). The draw unit may lock for up to 15 bytes.
- Address arithmetic is the requester's responsibility. The arbiter performs no increment or wrap; the 12-bit address passes through unchanged.

Decomposition:
- types package:
  - req_id_e enum (REQ_MEM = 0, REQ_DRAW = 1, REQ_FETCH = 2)
  - addr_t (logic [11:0])
  - byte_t (logic [7:0])
  - N_REQ = 3
  - arb_state_e (ARB_FREE, ARB_LOCKED)
- One sub-module, mem_arb_pick: a combinational fixed-priority picker with a promote input, returning a one-hot grant. State, lock, counter and muxing stay in mem_arbiter.

Test Plan:
- Reset: rst = 0 for 2 cycles while req = 3'b111, we = 3'b001 -> gnt = 0, mem_we = 0, rvalid = 0. After rst = 1, the first cycle gives gnt = 3'b001.
- Priority and latency: req = 3'b110, fetch addr = 0x200, draw addr = 0x050 read -> gnt = 3'b010, mem_addr = 0x050. Next cycle rvalid = 3'b010 and rdata = RAM[0x050]. stall = 3'b100 in the first cycle.
- Lock burst: mem stage writes 0x300..0x30F with lock = 1 except on the last byte, while req[2] is held high -> 16 consecutive gnt = 3'b001, fetch stalled throughout, then gnt = 3'b100 the following cycle.
- Lock drop: draw locked; draw deasserts req while mem stage requests -> gnt = 3'b001 in that same cycle.
- Starvation: mem stage and draw alternate unlocked requests continuously and fetch is held requesting -> fetch is granted exactly on the 9th cycle (starve_cnt = 8), then the counter clears.
- Reset mid-lock: reset asserted during a locked mem-stage burst at byte 5 -> no further mem_we; after release, FREE arbitration applies, with no residual lock and no stale rvalid.
